led_frame_scheduler: RTL and testbench

- Double-buffered frame store and sequencer sitting between host/pattern logic and led_driver.
- Answers led_driver's per-LED colour requests from a display bank while the host fills a write bank.
- Swaps banks only on frame boundaries and owns led_driver's force_reset, issuing timed strand restarts.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_frame_bank.sv | 48 ++++
 rtl/led_frame_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED frame scheduler: colour payload and scheduler states.
package led_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESTART = 2'd1,
        COPY    = 2'd2
    } sched_state_t;

endpackage

// File: rtl/led_frame_bank.sv
// Double frame store: bank_sel picks the display bank, writes go to the other bank.
// Display read is registered; LED_COPY_ON_SWAP_EN adds a combinational copy-read port.
module led_frame_bank
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 30,
    parameter int unsigned IDX_W    = $clog2(NUM_LEDS)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             bank_sel,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  rgb_t             wr_data,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [IDX_W-1:0] rd_addr,
    output rgb_t             rd_data
`ifdef LED_COPY_ON_SWAP_EN
    ,
    input  logic [IDX_W-1:0] copy_addr,
    output rgb_t             copy_data_c
`endif
);

    rgb_t mem [2][NUM_LEDS];

    // Frame storage, intentionally not cleared by reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[!bank_sel][wr_addr] <= wr_data;
        end
    end

    // Registered display read; rd_zero serves black (blanking or bad index).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_data <= RGB_BLACK;
        end else if (rd_en) begin
            rd_data <= rd_zero ? RGB_BLACK : mem[bank_sel][rd_addr];
        end
    end

`ifdef LED_COPY_ON_SWAP_EN
    assign copy_data_c = mem[bank_sel][copy_addr];
`endif

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered frame store and sequencer in front of led_driver.
// Flips banks on frame boundaries and issues timed strand restarts via force_reset.
// Optional LED_COPY_ON_SWAP_EN: after each flip, copy the new display bank into the write bank.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter  int unsigned NUM_LEDS          = 30,
    parameter  int unsigned RESET_HOLD_CYCLES = 8000,
    localparam int unsigned IDX_W             = $clog2(NUM_LEDS)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [23:0]      wr_color,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             swap_req,
    output logic             swap_done,
    input  logic             restart_in,
    input  logic             blank_in,
    input  logic [IDX_W-1:0] next_led_request,
    input  logic             request_valid,
    output logic [7:0]       red_out,
    output logic [7:0]       green_out,
    output logic [7:0]       blue_out,
    output logic             color_valid,
    output logic             force_reset,
    output logic             idx_err
);

    localparam int unsigned CNT_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES - 1);

    sched_state_t     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             bank_sel, bank_sel_d, bank_sel_eff;
    logic             swap_pending, pending_d;
    logic             swap_done_d, color_valid_d, idx_err_d, wr_ready_d, force_reset_d;
    logic             flip;
    logic             rd_en, rd_zero;
    logic             wr_en_m;
    logic [IDX_W-1:0] wr_addr_m;
    rgb_t             wr_data_m;
    rgb_t             rd_data;
    logic             req_oob, wr_oob;
`ifdef LED_COPY_ON_SWAP_EN
    logic [IDX_W-1:0] copy_idx, copy_idx_d;
    logic             copy_pending, copy_pending_d;
    rgb_t             copy_data_c;
`endif

    assign req_oob      = 32'(next_led_request) >= NUM_LEDS;
    assign wr_oob       = 32'(wr_addr) >= NUM_LEDS;
    assign bank_sel_eff = bank_sel ^ flip;

    assign red_out   = rd_data.r;
    assign green_out = rd_data.g;
    assign blue_out  = rd_data.b;

    // A flipping request is already served from the new display bank.
    led_frame_bank #(
        .NUM_LEDS (NUM_LEDS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .bank_sel    (bank_sel_eff),
        .wr_en       (wr_en_m),
        .wr_addr     (wr_addr_m),
        .wr_data     (wr_data_m),
        .rd_en       (rd_en),
        .rd_zero     (rd_zero),
        .rd_addr     (next_led_request),
        .rd_data     (rd_data)
`ifdef LED_COPY_ON_SWAP_EN
        ,
        .copy_addr   (copy_idx),
        .copy_data_c (copy_data_c)
`endif
    );

    // State and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= RUN;
            cnt          <= '0;
            bank_sel     <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
            color_valid  <= 1'b0;
            idx_err      <= 1'b0;
            force_reset  <= 1'b0;
            wr_ready     <= 1'b1;
`ifdef LED_COPY_ON_SWAP_EN
            copy_idx     <= '0;
            copy_pending <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bank_sel     <= bank_sel_d;
            swap_pending <= pending_d;
            swap_done    <= swap_done_d;
            color_valid  <= color_valid_d;
            idx_err      <= idx_err_d;
            force_reset  <= force_reset_d;
            wr_ready     <= wr_ready_d;
`ifdef LED_COPY_ON_SWAP_EN
            copy_idx     <= copy_idx_d;
            copy_pending <= copy_pending_d;
`endif
        end
    end

    // Next-state: swap handshake, host writes, serving and restart sequencing.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        bank_sel_d    = bank_sel;
        pending_d     = swap_pending;
        swap_done_d   = 1'b0;
        color_valid_d = color_valid;
        idx_err_d     = idx_err;
        flip          = 1'b0;
        rd_en         = 1'b0;
        rd_zero       = 1'b0;
        wr_en_m       = 1'b0;
        wr_addr_m     = wr_addr;
        wr_data_m     = rgb_t'(wr_color);
`ifdef LED_COPY_ON_SWAP_EN
        copy_idx_d     = copy_idx;
        copy_pending_d = copy_pending;
`endif

        // Flip at frame start, or straight away while the strand is held in reset.
        if ((swap_pending || swap_req) &&
            ((state == RESTART) || (request_valid && next_led_request == '0))) begin
            flip        = 1'b1;
            bank_sel_d  = !bank_sel;
            pending_d   = 1'b0;
            swap_done_d = 1'b1;
        end else if (swap_req) begin
            pending_d = 1'b1;
        end

        if (wr_valid && wr_ready) begin
            if (wr_oob) begin
                idx_err_d = 1'b1;
            end else begin
                wr_en_m = 1'b1;
            end
        end

        if (state != RESTART && request_valid) begin
            rd_en         = 1'b1;
            color_valid_d = 1'b1;
            if (req_oob) begin
                rd_zero   = 1'b1;
                idx_err_d = 1'b1;
            end
            if (blank_in) begin
                rd_zero = 1'b1;
            end
        end

        case (state)
            RUN: begin
                if (restart_in) begin
                    state_d       = RESTART;
                    cnt_d         = HOLD_LOAD;
                    color_valid_d = 1'b0;
`ifdef LED_COPY_ON_SWAP_EN
                    copy_pending_d = flip;
                end else if (flip) begin
                    state_d    = COPY;
                    copy_idx_d = '0;
`endif
                end
            end
            RESTART: begin
                color_valid_d = 1'b0;
`ifdef LED_COPY_ON_SWAP_EN
                copy_pending_d = copy_pending || flip;
`endif
                if (restart_in) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt == '0) begin
`ifdef LED_COPY_ON_SWAP_EN
                    if (copy_pending || flip) begin
                        state_d        = COPY;
                        copy_idx_d     = '0;
                        copy_pending_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
`ifdef LED_COPY_ON_SWAP_EN
            COPY: begin
                wr_en_m   = 1'b1;
                wr_addr_m = copy_idx;
                wr_data_m = copy_data_c;
                if (restart_in) begin
                    state_d        = RESTART;
                    cnt_d          = HOLD_LOAD;
                    color_valid_d  = 1'b0;
                    copy_pending_d = 1'b1;
                end else if (flip) begin
                    copy_idx_d = '0;
                end else if (copy_idx == IDX_W'(NUM_LEDS - 1)) begin
                    state_d = RUN;
                end else begin
                    copy_idx_d = copy_idx + 1'b1;
                end
            end
`endif
            default: state_d = RUN;
        endcase

        force_reset_d = (state_d == RESTART);
        // Hold the host off from swap request until one cycle after the flip, and during copy.
        wr_ready_d    = !(pending_d || swap_pending || state_d == COPY);
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler: table-driven serving plus swap/restart/reset sequences.
// Expectations adapt when LED_COPY_ON_SWAP_EN is defined.
module tb_led_frame_scheduler;
    import led_pkg::*;

    localparam int unsigned NUM_LEDS = 30;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned HOLD     = 8000;
`ifdef LED_COPY_ON_SWAP_EN
    localparam logic COPY_EN = 1'b1;
`else
    localparam logic COPY_EN = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [IDX_W-1:0] wr_addr;
    logic [23:0]      wr_color;
    logic             wr_valid;
    logic             wr_ready;
    logic             swap_req;
    logic             swap_done;
    logic             restart_in;
    logic             blank_in;
    logic [IDX_W-1:0] next_led_request;
    logic             request_valid;
    logic [7:0]       red_out, green_out, blue_out;
    logic             color_valid;
    logic             force_reset;
    logic             idx_err;

    always #5 clk_in = ~clk_in;

    led_frame_scheduler dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .wr_addr          (wr_addr),
        .wr_color         (wr_color),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .swap_req         (swap_req),
        .swap_done        (swap_done),
        .restart_in       (restart_in),
        .blank_in         (blank_in),
        .next_led_request (next_led_request),
        .request_valid    (request_valid),
        .red_out          (red_out),
        .green_out        (green_out),
        .blue_out         (blue_out),
        .color_valid      (color_valid),
        .force_reset      (force_reset),
        .idx_err          (idx_err)
    );

    typedef struct {
        int unsigned due;
        logic [23:0] exp;
    } sb_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             blank;
        logic [23:0]      exp;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vt[9];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [23:0] exp);
        sb_t e;
        e.due = cyc + 1;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Scoreboard: compare served colour one cycle after each counted request.
    always @(negedge clk_in) begin
        sb_t e;
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk($sformatf("serve_due%0d", e.due), {8'h00, red_out, green_out, blue_out}, {8'h00, e.exp});
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk_in);
    endtask

    task automatic do_write(input logic [IDX_W-1:0] a, input logic [23:0] c);
        @(negedge clk_in);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_color = c;
        @(negedge clk_in);
        wr_valid = 1'b0;
    endtask

    task automatic serve(input logic [IDX_W-1:0] idx, input logic blank, input logic [23:0] exp);
        @(negedge clk_in);
        request_valid    = 1'b1;
        next_led_request = idx;
        blank_in         = blank;
        push_exp(exp);
        @(negedge clk_in);
        request_valid = 1'b0;
        blank_in      = 1'b0;
    endtask

    task automatic swap_pulse();
        @(negedge clk_in);
        swap_req = 1'b1;
        @(negedge clk_in);
        swap_req = 1'b0;
    endtask

    initial begin
        vt[0] = '{idx: 5'd0,  blank: 1'b0, exp: 24'h010203};
        vt[1] = '{idx: 5'd5,  blank: 1'b0, exp: 24'hFF0000};
        vt[2] = '{idx: 5'd7,  blank: 1'b0, exp: 24'h00FF00};
        vt[3] = '{idx: 5'd7,  blank: 1'b1, exp: 24'h000000};
        vt[4] = '{idx: 5'd7,  blank: 1'b0, exp: 24'h00FF00};
        vt[5] = '{idx: 5'd3,  blank: 1'b0, exp: 24'h0000FF};
        vt[6] = '{idx: 5'd29, blank: 1'b0, exp: 24'h0A0B0C};
        vt[7] = '{idx: 5'd31, blank: 1'b0, exp: 24'h000000};
        vt[8] = '{idx: 5'd5,  blank: 1'b0, exp: 24'hFF0000};

        rst_in = 1'b1; wr_addr = '0; wr_color = '0; wr_valid = 1'b0;
        swap_req = 1'b0; restart_in = 1'b0; blank_in = 1'b0;
        next_led_request = '0; request_valid = 1'b0;

        // Reset values
        idle(2);
        chk("rst_colour", {8'h00, red_out, green_out, blue_out}, 32'h0);
        chk("rst_color_valid", color_valid, 1'b0);
        chk("rst_force_reset", force_reset, 1'b0);
        chk("rst_swap_done", swap_done, 1'b0);
        chk("rst_idx_err", idx_err, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        rst_in = 1'b0;

        // Fill write bank 1, request a swap, try a write while the swap is pending
        do_write(5'd0,  24'h010203);
        do_write(5'd3,  24'h0000FF);
        do_write(5'd5,  24'hFF0000);
        do_write(5'd7,  24'h00FF00);
        do_write(5'd29, 24'h0A0B0C);
        swap_pulse();
        chk("pending_wr_ready", wr_ready, 1'b0);
        chk("pending_no_done", swap_done, 1'b0);
        wr_valid = 1'b1; wr_addr = 5'd3; wr_color = 24'h123456;
        @(negedge clk_in);
        wr_valid = 1'b0;

        // Back-to-back serving table; first entry (idx 0) performs the flip
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_in);
            if (i == 1) begin
                chk("flip_swap_done", swap_done, 1'b1);
                chk("flip_color_valid", color_valid, 1'b1);
                chk("flip_wr_ready_low", wr_ready, 1'b0);
            end
            if (i == 2) begin
                chk("after_flip_done_low", swap_done, 1'b0);
                chk("after_flip_wr_ready", wr_ready, !COPY_EN);
            end
            request_valid    = 1'b1;
            next_led_request = vt[i].idx;
            blank_in         = vt[i].blank;
            push_exp(vt[i].exp);
        end
        @(negedge clk_in);
        request_valid = 1'b0;
        blank_in      = 1'b0;
        chk("idx_err_set", idx_err, 1'b1);

        // Bank 0 is now the write bank: edit it and flip back
        idle(32);
        chk("wr_ready_idle", wr_ready, 1'b1);
        do_write(5'd5, 24'hABCDEF);
        do_write(5'd0, 24'h0F0F0F);
        swap_pulse();
        serve(5'd0, 1'b0, 24'h0F0F0F);
        chk("swap2_done", swap_done, 1'b1);
        serve(5'd5, 1'b0, 24'hABCDEF);

        // Flip to bank 1 again: either a copy of bank 0 or its stale contents
        idle(32);
        chk("wr_ready_idle2", wr_ready, 1'b1);
        swap_pulse();
        serve(5'd0, 1'b0, COPY_EN ? 24'h0F0F0F : 24'h010203);
        serve(5'd5, 1'b0, COPY_EN ? 24'hABCDEF : 24'hFF0000);
        serve(5'd3, 1'b0, 24'h0000FF);

        // Restart with a pending swap
        idle(32);
        chk("idx_err_sticky", idx_err, 1'b1);
        @(negedge clk_in);
        swap_req = 1'b1;
        @(negedge clk_in);
        swap_req   = 1'b0;
        restart_in = 1'b1;
        @(negedge clk_in);
        restart_in = 1'b0;
        chk("restart_force_reset", force_reset, 1'b1);
        chk("restart_color_valid", color_valid, 1'b0);
        chk("restart_no_done_yet", swap_done, 1'b0);
        request_valid    = 1'b1;
        next_led_request = 5'd5;
        n = 1;
        @(negedge clk_in);
        request_valid = 1'b0;
        chk("restart_swap_done", swap_done, 1'b1);
        chk("restart_req_ignored", {8'h00, red_out, green_out, blue_out}, 32'h000000FF);
        if (force_reset) n++;
        while (n < 9000) begin
            @(negedge clk_in);
            if (!force_reset) break;
            n++;
        end
        chk("restart_hold_len", n, HOLD);
        chk("restart_color_valid_held", color_valid, 1'b0);
        idle(32);
        serve(5'd5, 1'b0, 24'hABCDEF);
        chk("color_valid_after_restart", color_valid, 1'b1);

        // Reset overrides a simultaneous restart and request
        @(negedge clk_in);
        rst_in = 1'b1; restart_in = 1'b1;
        request_valid = 1'b1; next_led_request = 5'd31;
        @(negedge clk_in);
        rst_in = 1'b0; restart_in = 1'b0; request_valid = 1'b0;
        chk("rst2_force_reset", force_reset, 1'b0);
        chk("rst2_idx_err", idx_err, 1'b0);
        chk("rst2_color_valid", color_valid, 1'b0);
        chk("rst2_colour", {8'h00, red_out, green_out, blue_out}, 32'h0);
        chk("rst2_wr_ready", wr_ready, 1'b1);

        // Out-of-range write is dropped and flagged
        do_write(5'd30, 24'h777777);
        chk("wr_oob_idx_err", idx_err, 1'b1);

        idle(2);
        chk("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
